// File: rtl/snake_pkg.sv
// Shared definitions for the snake movement engine.
// Holds the cell encodings, heading codes, the FSM state type, coordinate struct
// and the reverse-heading helper.
// Ports: none (package).
package snake_pkg;

  localparam int COORD_W = 10;

  localparam logic [3:0] CELL_EMPTY     = 4'b0000;
  localparam logic [3:0] CELL_OBST      = 4'b0001;
  localparam logic [3:0] CELL_FRUIT     = 4'b0010;
  localparam int         CELL_SNAKE_BIT = 3;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_TGT,
    ST_CHK_TGT,
    ST_WR_OLD,
    ST_WR_NEW,
    ST_RD_TAIL,
    ST_CHK_TAIL,
    ST_WR_TAIL,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  // Up<->down and right<->left differ only in bit 1 of the code.
  function automatic logic [1:0] rev_dir(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/snake_step_xy.sv
// One grid step from (x, y) in heading dir_i, wrapping at the map edges.
// Latency: combinational. Backpressure: none.
// Ports: x_i/y_i current cell, dir_i heading, x_o/y_o neighbouring cell.
module snake_step_xy
  import snake_pkg::*;
#(
  parameter int MAPA_WIDTH  = 40,
  parameter int MAPA_HEIGHT = 30
) (
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [1:0]         dir_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(MAPA_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(MAPA_HEIGHT - 1);

  // Wrap by compare-and-select so no divider is ever inferred.
  always_comb begin
    x_o = x_i;
    y_o = y_i;
    case (dir_i)
      DIR_UP:    y_o = (y_i == '0)    ? Y_MAX : y_i - COORD_W'(1);
      DIR_RIGHT: x_o = (x_i == X_MAX) ? '0    : x_i + COORD_W'(1);
      DIR_DOWN:  y_o = (y_i == Y_MAX) ? '0    : y_i + COORD_W'(1);
      default:   x_o = (x_i == '0)    ? X_MAX : x_i - COORD_W'(1);
    endcase
  end

endmodule

// File: rtl/snake_mover.sv
// Per-snake movement engine: on tick, reads the target cell, resolves collision/fruit,
// writes the new head and erases the tail. Latency: done at c8 (normal), c5 (fruit), c3 (death).
// Backpressure: ticks while busy, initialising or dead are dropped, never queued.
// Ports: clk/reset (sync, active-low); tick/dir_in step request; busy/done/ate/dead/length
// status; rd_en/rd_x/rd_y/rd_data map read port (data one cycle later); wr_* map write port.
module snake_mover
  import snake_pkg::*;
#(
  parameter int         MAPA_WIDTH  = 40,
  parameter int         MAPA_HEIGHT = 30,
  parameter int         SNAKE_ID    = 0,
  parameter int         START_X     = 10,
  parameter int         START_Y     = 15,
  parameter logic [1:0] START_DIR   = 2'b01,
  parameter int         LEN_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [1:0]         dir_in,
  output logic               busy,
  output logic               done,
  output logic               ate,
  output logic               dead,
  output logic [LEN_W-1:0]   length,
  output logic               rd_en,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  input  logic [3:0]         rd_data,
  output logic               wr_en,
  output logic [COORD_W-1:0] wr_x,
  output logic [COORD_W-1:0] wr_y,
  output logic [3:0]         wr_data
);

  localparam coord_t START_XY = {COORD_W'(START_X), COORD_W'(START_Y)};
  localparam logic   ID_BIT   = 1'(SNAKE_ID);

  state_t           state_q;
  coord_t           head_q, tail_q, new_head_q, rd_q, wr_q;
  logic [1:0]       heading_q, tail_dir_q, heading_d;
  logic             grow_q, dead_q, busy_q, done_q, ate_q, rd_en_q, wr_en_q;
  logic [LEN_W-1:0] length_q;
  logic [3:0]       wr_data_q;
  coord_t           head_step, tail_step;
  logic             tgt_blocked;

  function automatic logic [3:0] snake_cell(input logic [1:0] d);
    return {1'b1, ID_BIT, d};
  endfunction

  // A request for the exact reverse heading would fold the snake onto itself.
  assign heading_d   = (dir_in == rev_dir(heading_q)) ? heading_q : dir_in;
  assign tgt_blocked = rd_data[CELL_SNAKE_BIT] || (rd_data == CELL_OBST);

  snake_step_xy #(.MAPA_WIDTH(MAPA_WIDTH), .MAPA_HEIGHT(MAPA_HEIGHT)) u_head_step (
    .x_i(head_q.x), .y_i(head_q.y), .dir_i(heading_d),
    .x_o(head_step.x), .y_o(head_step.y)
  );

  snake_step_xy #(.MAPA_WIDTH(MAPA_WIDTH), .MAPA_HEIGHT(MAPA_HEIGHT)) u_tail_step (
    .x_i(tail_q.x), .y_i(tail_q.y), .dir_i(tail_dir_q),
    .x_o(tail_step.x), .y_o(tail_step.y)
  );

  // Outputs are registered on the transition into the state that owns them,
  // so each strobe lands exactly in its state's cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      head_q     <= START_XY;
      tail_q     <= START_XY;
      new_head_q <= START_XY;
      heading_q  <= START_DIR;
      tail_dir_q <= START_DIR;
      grow_q     <= 1'b0;
      length_q   <= LEN_W'(1);
      dead_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ate_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_q       <= '0;
      wr_q       <= '0;
      wr_data_q  <= '0;
    end else begin
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      ate_q   <= 1'b0;
      unique case (state_q)
        ST_INIT: begin
          wr_en_q   <= 1'b1;
          wr_q      <= START_XY;
          wr_data_q <= snake_cell(START_DIR);
          state_q   <= ST_IDLE;
        end
        ST_IDLE: begin
          if (tick && !dead_q) begin
            heading_q  <= heading_d;
            new_head_q <= head_step;
            rd_en_q    <= 1'b1;
            rd_q       <= head_step;
            busy_q     <= 1'b1;
            state_q    <= ST_RD_TGT;
          end
        end
        ST_RD_TGT: state_q <= ST_CHK_TGT;
        ST_CHK_TGT: begin
          if (tgt_blocked) begin
            dead_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            grow_q    <= (rd_data == CELL_FRUIT);
            wr_en_q   <= 1'b1;
            wr_q      <= head_q;
            wr_data_q <= snake_cell(heading_q);
            state_q   <= ST_WR_OLD;
          end
        end
        ST_WR_OLD: begin
          wr_en_q   <= 1'b1;
          wr_q      <= new_head_q;
          wr_data_q <= snake_cell(heading_q);
          state_q   <= ST_WR_NEW;
        end
        ST_WR_NEW: begin
          head_q <= new_head_q;
          if (grow_q) begin
            if (length_q != '1) length_q <= length_q + LEN_W'(1);
            done_q  <= 1'b1;
            ate_q   <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            rd_en_q <= 1'b1;
            rd_q    <= tail_q;
            state_q <= ST_RD_TAIL;
          end
        end
        ST_RD_TAIL: state_q <= ST_CHK_TAIL;
        ST_CHK_TAIL: begin
          // The tail cell's heading points at the next segment toward the head.
          tail_dir_q <= rd_data[1:0];
          wr_en_q    <= 1'b1;
          wr_q       <= tail_q;
          wr_data_q  <= CELL_EMPTY;
          state_q    <= ST_WR_TAIL;
        end
        ST_WR_TAIL: begin
          tail_q  <= tail_step;
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          grow_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ate     = ate_q;
  assign dead    = dead_q;
  assign length  = length_q;
  assign rd_en   = rd_en_q;
  assign rd_x    = rd_q.x;
  assign rd_y    = rd_q.y;
  assign wr_en   = wr_en_q;
  assign wr_x    = wr_q.x;
  assign wr_y    = wr_q.y;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_snake_mover.sv
// Directed bench for snake_mover with a small map memory answering the read/write ports.
// Each step window logs port events as {cycle, is_write, x, y, data} relative to the tick cycle.
// Ports: drives every snake_mover port by name.
module tb_snake_mover;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] dir_in = 2'b00;
  logic       busy, done, ate, dead;
  logic [7:0] length;
  logic       rd_en, wr_en;
  logic [9:0] rd_x, rd_y, wr_x, wr_y;
  logic [3:0] rd_data = 4'h0;
  logic [3:0] wr_data;

  always #5 clk = ~clk;

  snake_mover dut (
    .clk(clk), .reset(reset), .tick(tick), .dir_in(dir_in),
    .busy(busy), .done(done), .ate(ate), .dead(dead), .length(length),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data)
  );

  typedef logic [32:0] evw_t;  // {cyc[7:0], wr, x[9:0], y[9:0], data[3:0]}

  int         vecs = 0;
  int         errs = 0;
  logic [3:0] map [30][40];
  evw_t       evq[$];
  int         done_cyc, n_done, both_cnt;
  logic       ate_at_done, busy_c1, busy_after, busy_rst;
  logic [7:0] len_rst;

  function automatic evw_t mk(input int c, input bit w, input int x, input int y, input logic [3:0] d);
    return {8'(c), w, 10'(x), 10'(y), d};
  endfunction

  task automatic clear_map();
    foreach (map[i, j]) map[i][j] = 4'h0;
  endtask

  // Reset for one cycle, clear the map and let the INIT write land in it.
  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b0; tick = 1'b0; rd_data = 4'h0;
    @(posedge clk); #1;
    reset = 1'b1;
    clear_map();
    @(posedge clk); #1;
    @(negedge clk);
    if (wr_en && wr_x < 10'd40 && wr_y < 10'd30) map[wr_y][wr_x] = wr_data;
  endtask

  // Tick at cycle 0 and observe 15 cycles; optional extra tick / reset-low cycle.
  task automatic run_step(input logic [1:0] d, input int extra_tick, input int rst_cyc);
    logic       pend;
    logic [3:0] pv;
    evq.delete();
    done_cyc = -1; n_done = 0; both_cnt = 0;
    ate_at_done = 1'b0; busy_c1 = 1'b0; busy_after = 1'bx; busy_rst = 1'bx; len_rst = 'x;
    pend = 1'b0; pv = 4'h0;
    @(posedge clk); #1;
    tick = 1'b1; dir_in = d;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (rd_en) begin
        pv   = (rd_x < 10'd40 && rd_y < 10'd30) ? map[rd_y][rd_x] : 4'h0;
        pend = 1'b1;
        evq.push_back(mk(k, 1'b0, int'(rd_x), int'(rd_y), pv));
      end
      if (wr_en) begin
        if (wr_x < 10'd40 && wr_y < 10'd30) map[wr_y][wr_x] = wr_data;
        evq.push_back(mk(k, 1'b1, int'(wr_x), int'(wr_y), wr_data));
      end
      if (rd_en && wr_en) both_cnt++;
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin done_cyc = k; ate_at_done = ate; end
      end
      if (k == 1) busy_c1 = busy;
      if (done_cyc >= 0 && k == done_cyc + 1) busy_after = busy;
      if (rst_cyc >= 0 && k == rst_cyc + 1) begin busy_rst = busy; len_rst = length; end
      @(posedge clk); #1;
      tick    = (k + 1 == extra_tick);
      reset   = !(k + 1 == rst_cyc);
      rd_data = pend ? pv : 4'h0;
      pend    = 1'b0;
    end
    tick = 1'b0; reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; tick = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    clear_map();
    @(negedge clk);
    vecs++; if ({busy, done, ate, dead, rd_en, wr_en} !== 6'b0) begin
      errs++; $display("FAIL reset_flags: got %b want 000000", {busy, done, ate, dead, rd_en, wr_en}); end
    vecs++; if (length !== 8'd1) begin errs++; $display("FAIL reset_len: got %0d want 1", length); end
    vecs++; if ({rd_x, rd_y, wr_x, wr_y, wr_data} !== 44'h0) begin
      errs++; $display("FAIL reset_coords: got %h want 0", {rd_x, rd_y, wr_x, wr_y, wr_data}); end
    @(posedge clk); @(negedge clk);
    vecs++; if ({wr_en, wr_x, wr_y, wr_data} !== {1'b1, 10'd10, 10'd15, 4'b1001}) begin
      errs++; $display("FAIL init_write: got en=%b (%0d,%0d)=%b want en=1 (10,15)=1001", wr_en, wr_x, wr_y, wr_data); end
    if (wr_en && wr_x < 10'd40 && wr_y < 10'd30) map[wr_y][wr_x] = wr_data;
    @(posedge clk); @(negedge clk);
    vecs++; if ({wr_en, busy, dead, length} !== {3'b000, 8'd1}) begin
      errs++; $display("FAIL init_after: got wr_en=%b busy=%b dead=%b len=%0d want 0 0 0 1", wr_en, busy, dead, length); end
  endtask

  task automatic test_normal_step();
    evw_t exp[$];
    run_step(2'b01, -1, -1);
    exp = '{mk(1,0,11,15,4'h0), mk(3,1,10,15,4'h9), mk(4,1,11,15,4'h9), mk(5,0,10,15,4'h9), mk(7,1,10,15,4'h0)};
    vecs++; if (evq.size() != exp.size()) begin errs++; $display("FAIL normal_evcount: got %0d want %0d", evq.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < evq.size(); i++) begin
      vecs++; if (evq[i] !== exp[i]) begin errs++; $display("FAIL normal_ev%0d: got %h want %h", i, evq[i], exp[i]); end
    end
    vecs++; if (done_cyc != 8 || ate_at_done !== 1'b0 || n_done != 1) begin
      errs++; $display("FAIL normal_done: got cyc=%0d ate=%b n=%0d want 8 0 1", done_cyc, ate_at_done, n_done); end
    vecs++; if ({busy_c1, busy_after} !== 2'b10) begin errs++; $display("FAIL normal_busy: got %b want 10", {busy_c1, busy_after}); end
    vecs++; if (length !== 8'd1 || both_cnt != 0) begin errs++; $display("FAIL normal_len: got len=%0d both=%0d want 1 0", length, both_cnt); end
    // Tail must have advanced to (11,15).
    run_step(2'b01, -1, -1);
    vecs++; if (evq.size() != 5) begin errs++; $display("FAIL normal2_evcount: got %0d want 5", evq.size()); end
    else begin
      vecs++; if (evq[3] !== mk(5,0,11,15,4'h9)) begin errs++; $display("FAIL normal2_tailrd: got %h want %h", evq[3], mk(5,0,11,15,4'h9)); end
    end
  endtask

  task automatic test_fruit();
    evw_t exp[$];
    map[15][13] = 4'b0010;
    run_step(2'b01, -1, -1);
    exp = '{mk(1,0,13,15,4'h2), mk(3,1,12,15,4'h9), mk(4,1,13,15,4'h9)};
    vecs++; if (evq.size() != exp.size()) begin errs++; $display("FAIL fruit_evcount: got %0d want %0d", evq.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < evq.size(); i++) begin
      vecs++; if (evq[i] !== exp[i]) begin errs++; $display("FAIL fruit_ev%0d: got %h want %h", i, evq[i], exp[i]); end
    end
    vecs++; if (done_cyc != 5 || ate_at_done !== 1'b1 || busy_after !== 1'b0) begin
      errs++; $display("FAIL fruit_done: got cyc=%0d ate=%b busy=%b want 5 1 0", done_cyc, ate_at_done, busy_after); end
    vecs++; if (length !== 8'd2) begin errs++; $display("FAIL fruit_len: got %0d want 2", length); end
    // Length 2: tail stays at (12,15) and is erased on the next plain step.
    run_step(2'b01, -1, -1);
    exp = '{mk(1,0,14,15,4'h0), mk(3,1,13,15,4'h9), mk(4,1,14,15,4'h9), mk(5,0,12,15,4'h9), mk(7,1,12,15,4'h0)};
    vecs++; if (evq.size() != exp.size()) begin errs++; $display("FAIL grown_evcount: got %0d want %0d", evq.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < evq.size(); i++) begin
      vecs++; if (evq[i] !== exp[i]) begin errs++; $display("FAIL grown_ev%0d: got %h want %h", i, evq[i], exp[i]); end
    end
    vecs++; if (done_cyc != 8 || ate_at_done !== 1'b0 || length !== 8'd2) begin
      errs++; $display("FAIL grown_done: got cyc=%0d ate=%b len=%0d want 8 0 2", done_cyc, ate_at_done, length); end
  endtask

  task automatic test_wrap();
    logic [1:0] route [$];
    apply_reset();
    route = {};
    for (int i = 0; i < 8; i++) route.push_back(2'b00);
    for (int i = 0; i < 29; i++) route.push_back(2'b01);
    foreach (route[i]) begin
      run_step(route[i], -1, -1);
      vecs++; if (done_cyc != 8) begin errs++; $display("FAIL wrap_move%0d: done cyc got %0d want 8", i, done_cyc); end
    end
    run_step(2'b01, -1, -1);
    vecs++; if (evq.size() == 0 || evq[0] !== mk(1,0,0,7,4'h0)) begin
      errs++; $display("FAIL wrap_right: got %h want %h", evq.size() ? evq[0] : '0, mk(1,0,0,7,4'h0)); end
    apply_reset();
    route = {2'b00};
    for (int i = 0; i < 5; i++) route.push_back(2'b11);
    for (int i = 0; i < 14; i++) route.push_back(2'b00);
    foreach (route[i]) begin
      run_step(route[i], -1, -1);
      vecs++; if (done_cyc != 8) begin errs++; $display("FAIL wrap2_move%0d: done cyc got %0d want 8", i, done_cyc); end
    end
    run_step(2'b00, -1, -1);
    vecs++; if (evq.size() == 0 || evq[0] !== mk(1,0,5,29,4'h0)) begin
      errs++; $display("FAIL wrap_up: got %h want %h", evq.size() ? evq[0] : '0, mk(1,0,5,29,4'h0)); end
  endtask

  task automatic test_collision();
    apply_reset();
    map[15][11] = 4'b0001;
    run_step(2'b01, -1, -1);
    vecs++; if (evq.size() != 1 || evq[0] !== mk(1,0,11,15,4'h1)) begin
      errs++; $display("FAIL obst_events: got n=%0d first=%h want n=1 %h", evq.size(), evq.size() ? evq[0] : '0, mk(1,0,11,15,4'h1)); end
    vecs++; if (done_cyc != 3 || ate_at_done !== 1'b0 || dead !== 1'b1 || busy_after !== 1'b0) begin
      errs++; $display("FAIL obst_done: got cyc=%0d ate=%b dead=%b busy=%b want 3 0 1 0", done_cyc, ate_at_done, dead, busy_after); end
    run_step(2'b01, -1, -1);
    vecs++; if (evq.size() != 0 || n_done != 0 || dead !== 1'b1) begin
      errs++; $display("FAIL dead_tick: got events=%0d done=%0d dead=%b want 0 0 1", evq.size(), n_done, dead); end
    apply_reset();
    vecs++; if (dead !== 1'b0 || length !== 8'd1) begin errs++; $display("FAIL dead_clear: got dead=%b len=%0d want 0 1", dead, length); end
    map[14][10] = 4'b1100;
    run_step(2'b00, -1, -1);
    vecs++; if (evq.size() != 1 || evq[0] !== mk(1,0,10,14,4'hC)) begin
      errs++; $display("FAIL snake_events: got n=%0d first=%h want n=1 %h", evq.size(), evq.size() ? evq[0] : '0, mk(1,0,10,14,4'hC)); end
    vecs++; if (done_cyc != 3 || dead !== 1'b1) begin errs++; $display("FAIL snake_done: got cyc=%0d dead=%b want 3 1", done_cyc, dead); end
  endtask

  task automatic test_reverse_and_reset();
    evw_t exp[$];
    apply_reset();
    run_step(2'b11, -1, 4);
    exp = '{mk(1,0,11,15,4'h0), mk(3,1,10,15,4'h9), mk(4,1,11,15,4'h9), mk(6,1,10,15,4'h9)};
    vecs++; if (evq.size() != exp.size()) begin errs++; $display("FAIL rev_evcount: got %0d want %0d", evq.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < evq.size(); i++) begin
      vecs++; if (evq[i] !== exp[i]) begin errs++; $display("FAIL rev_ev%0d: got %h want %h", i, evq[i], exp[i]); end
    end
    vecs++; if (n_done != 0 || busy_rst !== 1'b0 || len_rst !== 8'd1) begin
      errs++; $display("FAIL midreset: got done=%0d busy=%b len=%0d want 0 0 1", n_done, busy_rst, len_rst); end
    clear_map();
    map[15][10] = 4'b1001;
    run_step(2'b00, -1, -1);
    vecs++; if (evq.size() == 0 || evq[0] !== mk(1,0,10,14,4'h0) || done_cyc != 8) begin
      errs++; $display("FAIL post_reset_step: got %h cyc=%0d want %h cyc=8", evq.size() ? evq[0] : '0, done_cyc, mk(1,0,10,14,4'h0)); end
  endtask

  task automatic test_back_to_back();
    evw_t exp[$];
    apply_reset();
    run_step(2'b01, 3, -1);
    exp = '{mk(1,0,11,15,4'h0), mk(3,1,10,15,4'h9), mk(4,1,11,15,4'h9), mk(5,0,10,15,4'h9), mk(7,1,10,15,4'h0)};
    vecs++; if (evq.size() != exp.size() || n_done != 1) begin
      errs++; $display("FAIL busytick_count: got events=%0d done=%0d want %0d 1", evq.size(), n_done, exp.size()); end
    for (int i = 0; i < exp.size() && i < evq.size(); i++) begin
      vecs++; if (evq[i] !== exp[i]) begin errs++; $display("FAIL busytick_ev%0d: got %h want %h", i, evq[i], exp[i]); end
    end
    run_step(2'b01, 8, -1);
    vecs++; if (evq.size() != 5 || n_done != 1 || done_cyc != 8) begin
      errs++; $display("FAIL donetick: got events=%0d done=%0d cyc=%0d want 5 1 8", evq.size(), n_done, done_cyc); end
  endtask

  initial begin
    test_reset();
    test_normal_step();
    test_fruit();
    test_wrap();
    test_collision();
    test_reverse_and_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/snake_mover.md
Name: snake_mover

Overview:
- Per-snake movement engine sitting directly upstream of the game map memory; it is the sole driver of the map's update read/write ports for one snake.
- On each game tick it computes the next head cell, reads the target cell, and resolves collision or fruit.
- It then writes the new head, and erases the tail unless the snake grew.
- One instance per snake (SNAKE_ID); arbitration between two instances is handled outside this block.

Parameters:
- MAPA_WIDTH, 40, grid columns; x range 0..MAPA_WIDTH-1.
- MAPA_HEIGHT, 30, grid rows; y range 0..MAPA_HEIGHT-1.
- SNAKE_ID, 0, value written into cell bit 2.
- START_X, 10, initial head/tail x.
- START_Y, 15, initial head/tail y.
- START_DIR, 2'b01, initial heading.
- LEN_W, 8, width of length counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- tick  in  1  single-cycle step request
- dir_in  in  2  requested heading: 00 up(y-1), 01 right(x+1), 10 down(y+1), 11 left(x-1)
- busy  out  1  high from the cycle after tick is accepted through DONE
- done  out  1  one-cycle pulse when a step finishes
- ate  out  1  one-cycle pulse, coincident with done, when fruit was eaten
- dead  out  1  sticky collision flag
- length  out  LEN_W  current segment count
- rd_en  out  1  map read request
- rd_x  out  10  read column
- rd_y  out  10  read row
- rd_data  in  4  cell read; valid in the cycle after rd_en
- wr_en  out  1  map write strobe
- wr_x  out  10  write column
- wr_y  out  10  write row
- wr_data  out  4  cell value

Behaviour:
- Cell encoding:
  - 0000 empty; 0001 obstacle; 0010 fruit.
  - Snake cell = {1, SNAKE_ID-or-other, dir}.
  - dir in a segment points toward the next segment nearer the head; in the head cell it is the current heading.
- Reset (reset==0 at posedge):
  - State goes to INIT; head = tail = (START_X, START_Y); heading = START_DIR; length = 1.
  - dead, busy, done, ate, rd_en, wr_en = 0; rd/wr coordinates and wr_data = 0.
  - Reset mid-step aborts immediately. The map is not repaired; clearing it is done elsewhere.
- FSM states and cycle timing (tick sampled in IDLE = cycle 0):
  - INIT: wr_en=1, writes {1,SNAKE_ID,START_DIR} at the start cell, then goes to IDLE.
  - IDLE: tick && !dead accepts a step.
    - Heading latches dir_in unless dir_in is the exact reverse of the current heading; in that case the heading is kept.
    - New head = head stepped by heading, with wrap-around: x=W-1 going right gives 0, x=0 going left gives W-1; same rule for y.
  - RD_TGT (c1): rd_en=1 at the new head.
  - CHK_TGT (c2): samples rd_data.
    - If bit3=1 (any snake, including own tail) or value 0001: dead<=1, go to DONE.
    - If value 0010: grow flag set. Otherwise the target is treated as empty.
  - WR_OLD (c3): writes {1,SNAKE_ID,heading} at the old head.
  - WR_NEW (c4): writes {1,SNAKE_ID,heading} at the new head; head<=new head.
    - If grow: length+1 (saturating at all-ones), go to DONE.
  - RD_TAIL (c5): rd_en=1 at the tail.
  - CHK_TAIL (c6): latches rd_data[1:0] as tail_dir.
  - WR_TAIL (c7): writes 0000 at the tail; tail <= tail stepped by tail_dir (same wrap rule).
  - DONE: done=1 (ate=1 if grow), busy=0 next cycle, return to IDLE.
    - Normal step: done at c8. Fruit: done at c5. Collision: done at c3.
- Tick handling:
  - tick while busy, in INIT, or while dead is ignored and not queued.
  - dead also blocks all map writes until reset.
- Port discipline: at most one of rd_en/wr_en is high per cycle; both are exactly one cycle wide.
- Coordinate arithmetic: 10-bit unsigned, wrap done by compare-and-select, never by modulo.

Decomposition:
- Package snake_pkg holds:
  - cell constants CELL_EMPTY, CELL_OBST, CELL_FRUIT, CELL_SNAKE_BIT;
  - direction codes DIR_UP/RIGHT/DOWN/LEFT;
  - an FSM state enum;
  - a function for the reverse direction.
- One sub-module, snake_step_xy: combinational (x, y, dir) -> (x', y') with wrap, parameterised by MAPA_WIDTH/MAPA_HEIGHT. It is instantiated twice: once for the head step and once for the tail step.

Test Plan:
1. Reset low one cycle, then high:
   - INIT writes (10,15) = 4'b1001 with a single wr_en pulse.
   - busy=0, length=1, dead=0.
2. tick with dir_in=01, rd_data=0000:
   - read (11,15) at c1.
   - writes (10,15)=1001 at c3 and (11,15)=1001 at c4.
   - read of (10,15) returns 1001; write (10,15)=0000 at c7.
   - done at c8; tail=(11,15).
3. Target returns 0010:
   - ate and done both high at c5; length=2.
   - no tail read or write.
4. Head at (39,7) heading right, tick: rd_x=0, rd_y=7. Head at (5,0) heading up: rd_y=29.
5. Target returns 0001 (or 1100):
   - dead=1, done at c3, no wr_en after tick.
   - a later tick produces no rd_en or wr_en activity.
6. Heading right, dir_in=11: read targets x+1.
   - Reset asserted at c4: next cycle is INIT (start cell written), busy=0, length=1.
   - A tick arriving during busy produces no second step.
